uart_param_of_verifla: RTL and testbench
========================================

# uart_param_of_verifla

Parametrised full-duplex UART for the VeriFLA debug link: internal fractional-free baud tick generator, TX engine with byte-level handshake, and 16x-oversampled RX engine feeding a small receive FIFO. Adds configurable word width, parity, stop bits, per-word error flags, overrun detection and glitch rejection. Sits between the logic-analyser control core and the board serial pins.

## Interface
- CLK_DIV, 27: sys_clk cycles per oversample tick (baud = f_clk / (16·CLK_DIV)); ≥2
- DATA_BITS, 8: data bits per frame; 5..8
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2
- RX_DEPTH, 4: RX FIFO entries; power of 2, ≥2

- sys_clk  in  1  system clock
- sys_rst_l  in  1  asynchronous, active-low reset
- baud_clk_posedge  out  1  one-cycle oversample tick
- txd_o  out  1  serial out, idle high
- wen_i  in  1  write strobe; accepted only when tre_o=1
- data_i  in  DATA_BITS  TX word
- tre_o  out  1  transmitter ready (idle, can accept)
- rxd_i  in  1  serial in, asynchronous
- data_o  out  DATA_BITS  head-of-FIFO RX word (show-ahead)
- rdy_o  out  1  RX FIFO not empty
- rd_i  in  1  pop; ignored when rdy_o=0
- parity_err_o  out  1  head word parity error (0 if PARITY=0)
- frame_err_o  out  1  head word stop-bit error
- overrun_o  out  1  sticky: word dropped on full FIFO

## Operation
- Tick: counter 0..CLK_DIV-1, baud_clk_posedge=1 for the cycle counter==CLK_DIV-1; free-running.
- TX states IDLE, START, DATA, PARITY, STOP. Accept in IDLE on wen_i: latch data_i, tre_o=0 next cycle, txd_o=0 next cycle, tick count cleared. Each bit lasts 16 ticks. Data LSB first. Parity bit: odd → total ones (data+parity) odd; even → even. STOP drives 1 for 16·STOP_BITS ticks, then IDLE, tre_o=1. wen_i while tre_o=0 ignored.
- RX: rxd_i through 2-flop synchroniser (reset value 1). States IDLE, START, DATA, PARITY, STOP.
  - IDLE: synchronised 0 → START, sample counter cleared.
  - START: at tick 8 resample; 1 → IDLE (glitch, no word); 0 → DATA.
  - Each later bit sampled every 16 ticks (mid-bit). STOP: each stop bit sampled; any 0 sets frame error. After last stop sample → IDLE immediately (resync mid-stop).
  - Word {frame_err, parity_err, data} written to FIFO; if full, word dropped, overrun_o=1.
- overrun_o clears on a rd_i pop or reset.
- Simultaneous push and pop on full FIFO: both happen, no overrun.

## Timing
- Reset values: txd_o=1, tre_o=1, rdy_o=0, data_o=0, parity_err_o=0, frame_err_o=0, overrun_o=0, baud_clk_posedge=0; all counters/FSMs idle, FIFO empty. Reset mid-frame aborts both directions; txd_o returns to 1 asynchronously.
- TX frame length: (1+DATA_BITS+(PARITY?1:0)+STOP_BITS)·16 ticks, start-bit first edge one cycle after acceptance (first bit may be short by <1 tick).
- RX latency: rdy_o rises 1 cycle after the final stop-bit sample; data_o/flags valid same cycle.
- rd_i pop: next head visible the following cycle; rdy_o drops same edge if last entry.
- FIFO pointers log2(RX_DEPTH)+1 bits, wrap naturally; full = MSBs differ, rest equal.

## Structure
- Package uart_of_verifla_pkg: parity mode constants (PAR_NONE/ODD/EVEN), TX/RX state encodings, OVERSAMPLE=16, MID_SAMPLE=8.
- One sub-module: sync_fifo_of_verifla (WIDTH, DEPTH; push/pop/full/empty, show-ahead); TX, RX and tick generator stay in the top.

## Test plan
- CLK_DIV=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; write 0xA5 → txd_o sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 64 cycles; tre_o=1 after stop.
- Loopback txd_o→rxd_i, send 0x00, 0xFF, 0x3C → rdy_o each time, data_o matches, both error flags 0.
- Drive frame 0xA5 with parity bit 1 → parity_err_o=1; frame with stop bit 0 → frame_err_o=1, word still stored.
- RX_DEPTH=4, send 5 words without rd_i → 4 stored in order, overrun_o=1; one rd_i → overrun_o=0, 3 remain.
- rxd_i low for 3 ticks then high → no word, RX back in IDLE, next valid frame 0x5A received correctly.
- Assert sys_rst_l low mid TX data bit and mid RX frame → txd_o=1 immediately, tre_o=1, rdy_o=0 after release; next 0x81 round-trips cleanly.

Source files
------------

// File: rtl/uart_of_verifla_pkg.sv
// Shared encodings for the VeriFLA UART: parity modes, FSM states, oversampling constants.
// No logic here beyond a parity helper used by both the TX and RX engines.
package uart_of_verifla_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity bit that makes the total ones count odd or even; zero padding of d is harmless.
    function automatic logic par_bit(input logic [7:0] d, input int mode);
        return (mode == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/sync_fifo_of_verifla.sv
// Show-ahead synchronous FIFO; pop_dat shows the head combinationally, zero when empty.
// Push on full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo_of_verifla #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_param_of_verifla.sv
// Full-duplex parametrised UART: tick generator, TX engine, 16x-oversampled RX into a small FIFO.
// TX starts one cycle after wen_i is accepted; RX word visible one cycle after final stop sample; RX drops words on full FIFO (sticky overrun).
module uart_param_of_verifla #(
    parameter int CLK_DIV   = 27,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_l,
    output logic                 baud_clk_posedge,
    output logic                 txd_o,
    input  logic                 wen_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tre_o,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 rdy_o,
    input  logic                 rd_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);
    import uart_of_verifla_pkg::*;

    localparam int             TW        = $clog2(CLK_DIV);
    localparam logic [TW-1:0]  DIV_LAST  = TW'(CLK_DIV - 1);
    localparam logic [3:0]     OS_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]     MID_LAST  = 4'(MID_SAMPLE - 1);
    localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
    localparam int             FW        = DATA_BITS + 2;

    logic [TW-1:0] div_cnt;
    logic          tick;

    assign tick             = (div_cnt == DIV_LAST);
    assign baud_clk_posedge = tick;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l)  div_cnt <= '0;
        else if (tick)   div_cnt <= '0;
        else             div_cnt <= div_cnt + 1'b1;
    end

    tx_state_t             tx_state, tx_state_nxt;
    logic [3:0]            tx_cnt, tx_cnt_nxt;
    logic [2:0]            tx_bit, tx_bit_nxt;
    logic [DATA_BITS-1:0]  tx_data, tx_data_nxt;
    logic                  txd, txd_nxt;
    logic                  tx_par;

    assign tx_par = par_bit(8'(tx_data), PARITY);
    assign tre_o  = (tx_state == TX_IDLE);
    assign txd_o  = txd;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_data_nxt  = tx_data;
        txd_nxt      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (wen_i) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_data_nxt  = data_i;
                end
            end
            TX_START, TX_DATA, TX_PARITY, TX_STOP: begin
                if (tick) begin
                    if (tx_cnt != OS_LAST) begin
                        tx_cnt_nxt = tx_cnt + 4'd1;
                    end else begin
                        tx_cnt_nxt = '0;
                        if (tx_state == TX_START) begin
                            tx_state_nxt = TX_DATA;
                            tx_bit_nxt   = '0;
                        end else if (tx_state == TX_DATA) begin
                            if (tx_bit == DATA_LAST) begin
                                tx_bit_nxt   = '0;
                                tx_state_nxt = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                            end else begin
                                tx_bit_nxt = tx_bit + 3'd1;
                            end
                        end else if (tx_state == TX_PARITY) begin
                            tx_state_nxt = TX_STOP;
                            tx_bit_nxt   = '0;
                        end else if (tx_bit == STOP_LAST) begin
                            tx_state_nxt = TX_IDLE;
                        end else begin
                            tx_bit_nxt = tx_bit + 3'd1;
                        end
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        // Line level is registered from the next state so the pin never glitches.
        case (tx_state_nxt)
            TX_START:  txd_nxt = 1'b0;
            TX_DATA:   txd_nxt = tx_data_nxt[tx_bit_nxt];
            TX_PARITY: txd_nxt = tx_par;
            default:   txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_data  <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_data  <= tx_data_nxt;
            txd      <= txd_nxt;
        end
    end

    logic [1:0]            rx_sync;
    logic                  rx_in;
    rx_state_t             rx_state, rx_state_nxt;
    logic [3:0]            rx_cnt, rx_cnt_nxt;
    logic [2:0]            rx_bit, rx_bit_nxt;
    logic [DATA_BITS-1:0]  rx_shift, rx_shift_nxt;
    logic                  rx_par, rx_par_nxt;
    logic                  rx_ferr, rx_ferr_nxt;
    logic                  rx_perr;
    logic                  push, push_nxt;
    logic [FW-1:0]         push_word, push_word_nxt;

    assign rx_in   = rx_sync[1];
    assign rx_perr = (PARITY != PAR_NONE) && (rx_par != par_bit(8'(rx_shift), PARITY));

    always_comb begin
        rx_state_nxt  = rx_state;
        rx_cnt_nxt    = rx_cnt;
        rx_bit_nxt    = rx_bit;
        rx_shift_nxt  = rx_shift;
        rx_par_nxt    = rx_par;
        rx_ferr_nxt   = rx_ferr;
        push_nxt      = 1'b0;
        push_word_nxt = push_word;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_in) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                    rx_ferr_nxt  = 1'b0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_cnt == MID_LAST) begin
                        rx_cnt_nxt   = '0;
                        rx_bit_nxt   = '0;
                        rx_state_nxt = rx_in ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_nxt = rx_cnt + 4'd1;
                    end
                end
            end
            RX_DATA, RX_PARITY, RX_STOP: begin
                if (tick) begin
                    if (rx_cnt != OS_LAST) begin
                        rx_cnt_nxt = rx_cnt + 4'd1;
                    end else begin
                        rx_cnt_nxt = '0;
                        if (rx_state == RX_DATA) begin
                            rx_shift_nxt = {rx_in, rx_shift[DATA_BITS-1:1]};
                            if (rx_bit == DATA_LAST) begin
                                rx_bit_nxt   = '0;
                                rx_state_nxt = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_nxt = rx_bit + 3'd1;
                            end
                        end else if (rx_state == RX_PARITY) begin
                            rx_par_nxt   = rx_in;
                            rx_bit_nxt   = '0;
                            rx_state_nxt = RX_STOP;
                        end else begin
                            rx_ferr_nxt = rx_ferr | ~rx_in;
                            // Leave mid-stop so a back-to-back start edge is not missed.
                            if (rx_bit == STOP_LAST) begin
                                rx_state_nxt  = RX_IDLE;
                                push_nxt      = 1'b1;
                                push_word_nxt = {rx_ferr | ~rx_in, rx_perr, rx_shift};
                            end else begin
                                rx_bit_nxt = rx_bit + 3'd1;
                            end
                        end
                    end
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            rx_sync   <= 2'b11;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_par    <= 1'b0;
            rx_ferr   <= 1'b0;
            push      <= 1'b0;
            push_word <= '0;
        end else begin
            rx_sync   <= {rx_sync[0], rxd_i};
            rx_state  <= rx_state_nxt;
            rx_cnt    <= rx_cnt_nxt;
            rx_bit    <= rx_bit_nxt;
            rx_shift  <= rx_shift_nxt;
            rx_par    <= rx_par_nxt;
            rx_ferr   <= rx_ferr_nxt;
            push      <= push_nxt;
            push_word <= push_word_nxt;
        end
    end

    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] head;

    sync_fifo_of_verifla #(
        .WIDTH (FW),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk      (sys_clk),
        .rst_n    (sys_rst_l),
        .push     (push),
        .push_dat (push_word),
        .pop      (rd_i),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign {frame_err_o, parity_err_o, data_o} = head;
    assign rdy_o = !fifo_empty;

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l)                 overrun_o <= 1'b0;
        else if (rd_i && !fifo_empty)   overrun_o <= 1'b0;
        else if (push && fifo_full)     overrun_o <= 1'b1;
    end

endmodule

// File: tb/tb_uart_param_of_verifla.sv
// Directed bench for uart_param_of_verifla at CLK_DIV=4, 8E1, 4-deep RX FIFO (one bit = 64 cycles).
module tb_uart_param_of_verifla;

    localparam int BIT = 64;

    logic       sys_clk;
    logic       sys_rst_l;
    logic       baud_clk_posedge;
    logic       txd_o;
    logic       wen_i;
    logic [7:0] data_i;
    logic       tre_o;
    logic       rxd;
    logic [7:0] data_o;
    logic       rdy_o;
    logic       rd_i;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       loop;
    logic       rxd_drv;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       lp;
        logic [7:0] dat;
        logic       par_flip;
        logic       stop_val;
        logic [7:0] exp_dat;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    assign rxd = loop ? txd_o : rxd_drv;

    uart_param_of_verifla #(
        .CLK_DIV   (4),
        .DATA_BITS (8),
        .PARITY    (2),
        .STOP_BITS (1),
        .RX_DEPTH  (4)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst_l        (sys_rst_l),
        .baud_clk_posedge (baud_clk_posedge),
        .txd_o            (txd_o),
        .wen_i            (wen_i),
        .data_i           (data_i),
        .tre_o            (tre_o),
        .rxd_i            (rxd),
        .data_o           (data_o),
        .rdy_o            (rdy_o),
        .rd_i             (rd_i),
        .parity_err_o     (parity_err_o),
        .frame_err_o      (frame_err_o),
        .overrun_o        (overrun_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Even parity; a stop value of 0 is held for 3/4 bit so the line is idle again before any resync sample.
    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop_v);
        rxd_drv = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            cyc(BIT);
        end
        rxd_drv = (^d) ^ pflip;
        cyc(BIT);
        rxd_drv = stop_v;
        if (stop_v) begin
            cyc(BIT);
        end else begin
            cyc(48);
            rxd_drv = 1'b1;
            cyc(16);
        end
        rxd_drv = 1'b1;
        cyc(2 * BIT);
    endtask

    task automatic wait_tre(input string tag);
        int n = 0;
        while (!tre_o && n < 3000) begin
            cyc(1);
            n++;
        end
        check($sformatf("%s tre_o ready", tag), tre_o, 1);
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!rdy_o && n < 3000) begin
            cyc(1);
            n++;
        end
        check($sformatf("%s rdy_o", tag), rdy_o, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        if (v.lp) begin
            loop = 1'b1;
            wait_tre(tag);
            data_i = v.dat;
            wen_i  = 1'b1;
            cyc(1);
            wen_i  = 1'b0;
        end else begin
            loop = 1'b0;
            send_frame(v.dat, v.par_flip, v.stop_val);
        end
        wait_rdy(tag);
        check($sformatf("%s data_o", tag), data_o, v.exp_dat);
        check($sformatf("%s parity_err_o", tag), parity_err_o, v.exp_perr);
        check($sformatf("%s frame_err_o", tag), frame_err_o, v.exp_ferr);
        rd_i = 1'b1;
        cyc(1);
        rd_i = 1'b0;
        check($sformatf("%s rdy_o after pop", tag), rdy_o, 0);
        if (v.lp) wait_tre(tag);
        loop = 1'b0;
    endtask

    initial begin
        vec_t       tbl[5];
        vec_t       hv;
        logic       txexp[11];
        logic [7:0] ovr[5];
        int         cur;
        int         tk;

        tbl[0] = '{lp: 1'b1, dat: 8'h00, par_flip: 1'b0, stop_val: 1'b1, exp_dat: 8'h00, exp_perr: 1'b0, exp_ferr: 1'b0};
        tbl[1] = '{lp: 1'b1, dat: 8'hFF, par_flip: 1'b0, stop_val: 1'b1, exp_dat: 8'hFF, exp_perr: 1'b0, exp_ferr: 1'b0};
        tbl[2] = '{lp: 1'b1, dat: 8'h3C, par_flip: 1'b0, stop_val: 1'b1, exp_dat: 8'h3C, exp_perr: 1'b0, exp_ferr: 1'b0};
        tbl[3] = '{lp: 1'b0, dat: 8'hA5, par_flip: 1'b1, stop_val: 1'b1, exp_dat: 8'hA5, exp_perr: 1'b1, exp_ferr: 1'b0};
        tbl[4] = '{lp: 1'b0, dat: 8'hA5, par_flip: 1'b0, stop_val: 1'b0, exp_dat: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b1};
        txexp  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ovr    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        sys_rst_l = 1'b0;
        wen_i     = 1'b0;
        data_i    = 8'h00;
        rd_i      = 1'b0;
        loop      = 1'b0;
        rxd_drv   = 1'b1;
        cyc(3);

        check("reset txd_o", txd_o, 1);
        check("reset tre_o", tre_o, 1);
        check("reset rdy_o", rdy_o, 0);
        check("reset data_o", data_o, 0);
        check("reset parity_err_o", parity_err_o, 0);
        check("reset frame_err_o", frame_err_o, 0);
        check("reset overrun_o", overrun_o, 0);
        check("reset baud_clk_posedge", baud_clk_posedge, 0);

        sys_rst_l = 1'b1;
        tk = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            tk += int'(baud_clk_posedge);
        end
        check("tick count in 40 cycles", tk, 10);

        // TX waveform of 0xA5 with even parity; bit k is sampled 64k+32 cycles after acceptance.
        data_i = 8'hA5;
        wen_i  = 1'b1;
        cyc(1);
        wen_i  = 1'b0;
        check("tx tre_o after accept", tre_o, 0);
        check("tx txd_o after accept", txd_o, 0);
        cur = 0;
        for (int k = 0; k < 11; k++) begin
            cyc(BIT * k + 32 - cur);
            cur = BIT * k + 32;
            check($sformatf("tx bit %0d", k), txd_o, txexp[k]);
            if (k == 2) begin
                data_i = 8'h00;
                wen_i  = 1'b1;
                cyc(1);
                wen_i  = 1'b0;
                cur++;
            end
        end
        cyc(11 * BIT + 1 - cur);
        check("tx tre_o after stop", tre_o, 1);
        check("tx txd_o idle after stop", txd_o, 1);

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Start-bit glitch of 3 ticks must be rejected.
        loop    = 1'b0;
        rxd_drv = 1'b0;
        cyc(12);
        rxd_drv = 1'b1;
        cyc(200);
        check("glitch no word", rdy_o, 0);
        hv = '{lp: 1'b0, dat: 8'h5A, par_flip: 1'b0, stop_val: 1'b1, exp_dat: 8'h5A, exp_perr: 1'b0, exp_ferr: 1'b0};
        run_vec(hv, "post-glitch");

        // Five words into a 4-deep FIFO: fifth dropped, overrun sticky until a pop.
        for (int j = 0; j < 5; j++) begin
            send_frame(ovr[j], 1'b0, 1'b1);
            if (j == 3) check("overrun before full+push", overrun_o, 0);
        end
        check("overrun set", overrun_o, 1);
        check("overrun rdy_o", rdy_o, 1);
        check("overrun head", data_o, 8'h11);
        rd_i = 1'b1;
        cyc(1);
        rd_i = 1'b0;
        check("overrun cleared by pop", overrun_o, 0);
        for (int j = 1; j < 4; j++) begin
            check($sformatf("fifo entry %0d", j), data_o, ovr[j]);
            rd_i = 1'b1;
            cyc(1);
            rd_i = 1'b0;
        end
        check("fifo drained", rdy_o, 0);

        // Reset in the middle of a looped-back TX frame of 0x00.
        loop   = 1'b1;
        data_i = 8'h00;
        wen_i  = 1'b1;
        cyc(1);
        wen_i  = 1'b0;
        cyc(3 * BIT);
        check("pre-reset txd_o in data bit", txd_o, 0);
        sys_rst_l = 1'b0;
        #1;
        check("async reset txd_o", txd_o, 1);
        check("async reset tre_o", tre_o, 1);
        cyc(2);
        sys_rst_l = 1'b1;
        cyc(1);
        check("post-reset rdy_o", rdy_o, 0);
        check("post-reset tre_o", tre_o, 1);
        cyc(1000);
        check("post-reset no stray word", rdy_o, 0);
        hv = '{lp: 1'b1, dat: 8'h81, par_flip: 1'b0, stop_val: 1'b1, exp_dat: 8'h81, exp_perr: 1'b0, exp_ferr: 1'b0};
        run_vec(hv, "post-reset 0x81");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
